// File: rtl/uart_io_pkg.sv
// Shared types for the core <-> UART I/O channel: FSM states, request/response bundles and helpers.
// Core side and uart_io_server both pack/unpack through these so field order cannot drift.
package uart_io_pkg;

    localparam int unsigned LEN_UART_SIZE = 2;
    localparam int unsigned TO_UART_W     = 1 + LEN_UART_SIZE + 32 + 1;
    localparam int unsigned FROM_UART_W   = 1 + 1 + 32;

    typedef enum logic [1:0] {
        StIdle,
        StTx,
        StRx,
        StDone
    } io_state_e;

    typedef struct packed {
        logic                     order;
        logic [LEN_UART_SIZE-1:0] size;
        logic [31:0]              data;
        logic                     write;
    } to_uart_t;

    typedef struct packed {
        logic        accepted;
        logic        done;
        logic [31:0] data;
    } from_uart_t;

    // Size field is "bytes minus one", so it is directly the index of the final byte.
    function automatic logic [LEN_UART_SIZE-1:0] size_to_last_idx(
        input logic [LEN_UART_SIZE-1:0] size
    );
        return size;
    endfunction

    function automatic logic [TO_UART_W-1:0] pack_to_uart(input to_uart_t req);
        return req;
    endfunction

    function automatic to_uart_t unpack_to_uart(input logic [TO_UART_W-1:0] bits);
        return to_uart_t'(bits);
    endfunction

    function automatic logic [FROM_UART_W-1:0] pack_from_uart(input from_uart_t resp);
        return resp;
    endfunction

    function automatic from_uart_t unpack_from_uart(input logic [FROM_UART_W-1:0] bits);
        return from_uart_t'(bits);
    endfunction

endpackage

// File: rtl/io_byte_lane.sv
// Byte counter plus lane mux (TX) / demux (RX) with endian select.
// The lane for the current byte is derived from the counter and the transfer size.
module io_byte_lane
    import uart_io_pkg::*;
#(
    parameter int unsigned LittleEndian = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     advance_i,
    input  logic [LEN_UART_SIZE-1:0] size_i,
    input  logic [31:0]              tx_word_i,
    input  logic [31:0]              rx_word_i,
    input  logic [7:0]               rx_byte_i,
    output logic                     last_o,
    output logic [7:0]               tx_byte_o,
    output logic [31:0]              rx_word_o
);

    logic [LEN_UART_SIZE-1:0] count_q;
    logic [LEN_UART_SIZE-1:0] lane;
    logic [4:0]               bit_ofs;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (advance_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Big-endian transfers are right-aligned: byte 0 sits in lane `size`, the last in lane 0.
    assign lane    = (LittleEndian != 0) ? count_q : size_i - count_q;
    assign bit_ofs = {lane, 3'b000};

    always_comb begin
        last_o    = (count_q == size_to_last_idx(size_i));
        tx_byte_o = tx_word_i[bit_ofs +: 8];
        rx_word_o = rx_word_i;
        rx_word_o[bit_ofs +: 8] = rx_byte_i;
    end

endmodule

// File: rtl/uart_io_server.sv
// UART-side responder for the core I/O request channel: serialises writes to TX,
// assembles reads from RX, one request at a time, with a one-cycle done pulse.
module uart_io_server
    import uart_io_pkg::*;
#(
    parameter int unsigned LITTLE_ENDIAN = 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     req_order,
    input  logic [LEN_UART_SIZE-1:0] req_size,
    input  logic [31:0]              req_data,
    input  logic                     req_write,
    output logic                     resp_accepted,
    output logic                     resp_done,
    output logic [31:0]              resp_data,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     busy
);

    io_state_e                state_q, state_d;
    to_uart_t                 req;
    from_uart_t               resp;
    logic [LEN_UART_SIZE-1:0] size_q;
    logic [31:0]              data_q;
    logic                     write_q;
    logic [31:0]              result_q;
    logic [31:0]              resp_hold_q;
    logic                     accept;
    logic                     tx_fire;
    logic                     rx_fire;
    logic                     last_byte;
    logic [7:0]               lane_tx_byte;
    logic [31:0]              lane_rx_word;

    assign req     = unpack_to_uart({req_order, req_size, req_data, req_write});
    assign accept  = (state_q == StIdle) && req.order;
    assign tx_fire = (state_q == StTx) && tx_ready;
    assign rx_fire = (state_q == StRx) && rx_valid;

    io_byte_lane #(
        .LittleEndian (LITTLE_ENDIAN)
    ) u_lane (
        .clk_i     (clk),
        .rst_i     (rstn),
        .clear_i   (accept),
        .advance_i (tx_fire || rx_fire),
        .size_i    (size_q),
        .tx_word_i (data_q),
        .rx_word_i (result_q),
        .rx_byte_i (rx_data),
        .last_o    (last_byte),
        .tx_byte_o (lane_tx_byte),
        .rx_word_o (lane_rx_word)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req.order) state_d = req.write ? StTx : StRx;
            StTx:   if (tx_ready && last_byte) state_d = StDone;
            StRx:   if (rx_valid && last_byte) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        resp.accepted = 1'b0;
        resp.done     = 1'b0;
        resp.data     = resp_hold_q;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        rx_ready      = 1'b0;
        busy          = (state_q != StIdle);
        unique case (state_q)
            StIdle: resp.accepted = req.order;
            StTx: begin
                tx_valid = 1'b1;
                tx_data  = lane_tx_byte;
            end
            StRx:   rx_ready = 1'b1;
            StDone: begin
                resp.done = 1'b1;
                resp.data = write_q ? 32'h0 : result_q;
            end
            default: ;
        endcase
    end

    assign {resp_accepted, resp_done, resp_data} = pack_from_uart(resp);

    // resp_data is held from the last DONE so the requester can sample it late.
    always_ff @(posedge clk) begin
        if (rstn) begin
            size_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            result_q    <= '0;
            resp_hold_q <= '0;
        end else begin
            if (accept) begin
                size_q   <= req.size;
                data_q   <= req.data;
                write_q  <= req.write;
                result_q <= '0;
            end else if (rx_fire) begin
                result_q <= lane_rx_word;
            end
            if (state_q == StDone) begin
                resp_hold_q <= resp.data;
            end
        end
    end

endmodule

// File: tb/tb_uart_io_server.sv
// Bench for uart_io_server: a little-endian and a big-endian instance share all inputs
// and are checked against a byte-sequence model derived from the endianness rules.
module tb_uart_io_server;

    logic       clk = 1'b0;
    logic       rstn;
    logic       req_order;
    logic [1:0] req_size;
    logic [31:0] req_data;
    logic       req_write;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    // Index 0: LITTLE_ENDIAN=1, index 1: LITTLE_ENDIAN=0.
    logic        acc [2];
    logic        done [2];
    logic [31:0] rdata [2];
    logic [7:0]  txd [2];
    logic        txv [2];
    logic        rxr [2];
    logic        bsy [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_io_server #(.LITTLE_ENDIAN(1)) dut_le (
        .clk(clk), .rstn(rstn), .req_order(req_order), .req_size(req_size),
        .req_data(req_data), .req_write(req_write), .resp_accepted(acc[0]),
        .resp_done(done[0]), .resp_data(rdata[0]), .tx_data(txd[0]), .tx_valid(txv[0]),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rxr[0]),
        .busy(bsy[0])
    );

    uart_io_server #(.LITTLE_ENDIAN(0)) dut_be (
        .clk(clk), .rstn(rstn), .req_order(req_order), .req_size(req_size),
        .req_data(req_data), .req_write(req_write), .resp_accepted(acc[1]),
        .resp_done(done[1]), .resp_data(rdata[1]), .tx_data(txd[1]), .tx_valid(txv[1]),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rxr[1]),
        .busy(bsy[1])
    );

    // Per-transaction stimulus and observations, filled by do_txn.
    int          stall [4];
    logic [7:0]  rxb [4];
    logic [7:0]  obs_tx [2][4];
    logic        obs_acc [2];
    logic        obs_done [2];
    logic        obs_early [2];
    logic        obs_side_ok [2];
    logic        obs_stall_ok [2];
    logic [31:0] obs_data [2];
    logic [7:0]  prev [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte k of an n-byte write as it should appear on TX.
    function automatic logic [7:0] exp_tx(input int j, input logic [31:0] d, input int n,
                                          input int k);
        if (j == 0) return 8'((d >> (8 * k)) & 32'hff);
        return 8'((d >> (8 * (n - 1 - k))) & 32'hff);
    endfunction

    // Read result from rxb[0..n-1]: LE places byte k at weight 256^k, BE shifts in MSB-first.
    function automatic logic [31:0] exp_rd(input int j, input int n);
        logic [31:0] r = 32'h0;
        for (int k = 0; k < n; k++) begin
            if (j == 0) r = r | (32'(rxb[k]) << (8 * k));
            else        r = (r << 8) | 32'(rxb[k]);
        end
        return r;
    endfunction

    // Runs one transaction starting in an IDLE cycle; records only, compares nothing.
    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = int'(sz) + 1;
        req_order = 1'b1; req_size = sz; req_data = d; req_write = wr;
        tx_ready = 1'b0; rx_valid = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            obs_acc[j] = acc[j]; obs_early[j] = 1'b0;
            obs_side_ok[j] = 1'b1; obs_stall_ok[j] = 1'b1;
        end
        tick();
        req_order = 1'b0; req_size = 2'($urandom); req_data = $urandom;
        req_write = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            for (int s = 0; s < stall[k]; s++) begin
                tx_ready = 1'b0;
                rx_valid = wr ? 1'($urandom) : 1'b0;
                rx_data = 8'($urandom);
                #1;
                for (int j = 0; j < 2; j++) begin
                    if (done[j]) obs_early[j] = 1'b1;
                    if (wr) begin
                        if (!txv[j] || rxr[j]) obs_side_ok[j] = 1'b0;
                        if (s > 0 && txd[j] !== prev[j]) obs_stall_ok[j] = 1'b0;
                        prev[j] = txd[j];
                    end else if (!rxr[j] || txv[j]) begin
                        obs_side_ok[j] = 1'b0;
                    end
                end
                tick();
            end
            if (wr) begin
                tx_ready = 1'b1; rx_valid = 1'($urandom); rx_data = 8'($urandom);
            end else begin
                rx_valid = 1'b1; rx_data = rxb[k]; tx_ready = 1'($urandom);
            end
            #1;
            for (int j = 0; j < 2; j++) begin
                if (done[j]) obs_early[j] = 1'b1;
                obs_tx[j][k] = txd[j];
                if (wr) begin
                    if (!txv[j] || rxr[j]) obs_side_ok[j] = 1'b0;
                    if (stall[k] > 0 && txd[j] !== prev[j]) obs_stall_ok[j] = 1'b0;
                end else if (!rxr[j] || txv[j]) begin
                    obs_side_ok[j] = 1'b0;
                end
            end
            tick();
        end
        tx_ready = 1'b0; rx_valid = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            obs_done[j] = done[j];
            obs_data[j] = rdata[j];
            if (txv[j] || rxr[j] || !bsy[j]) obs_side_ok[j] = 1'b0;
        end
        tick();
    endtask

    task automatic test_reset();
        rstn = 1'b1; req_order = 1'b0; req_size = 2'($urandom); req_data = $urandom;
        req_write = 1'($urandom); tx_ready = 1'($urandom); rx_valid = 1'($urandom);
        rx_data = 8'($urandom);
        tick(); tick();
        rstn = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({acc[j], done[j], txv[j], rxr[j], bsy[j]} !== 5'b0)
                begin n_bad++; $display("FAIL reset_flags dut%0d: got %b want 00000", j,
                    {acc[j], done[j], txv[j], rxr[j], bsy[j]}); end
            n_cmp++;
            if (rdata[j] !== 32'h0)
                begin n_bad++; $display("FAIL reset_rdata dut%0d: got %h want 0", j, rdata[j]); end
            n_cmp++;
            if (txd[j] !== 8'h0)
                begin n_bad++; $display("FAIL reset_txd dut%0d: got %h want 0", j, txd[j]); end
        end
        tick();
    endtask

    task automatic test_write_plan();
        logic [31:0] seq [2];
        seq[0] = 32'h44332211; seq[1] = 32'h11223344;
        stall = '{0, 0, 0, 0};
        do_txn(1'b1, 2'd3, 32'h11223344);
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (obs_acc[j] !== 1'b1)
                begin n_bad++; $display("FAIL wplan_acc dut%0d: got %b want 1", j, obs_acc[j]); end
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (obs_tx[j][k] !== seq[j][31 - 8 * k -: 8])
                    begin n_bad++; $display("FAIL wplan_byte%0d dut%0d: got %h want %h", k, j,
                        obs_tx[j][k], seq[j][31 - 8 * k -: 8]); end
            end
            n_cmp++;
            if ({obs_done[j], obs_early[j], obs_side_ok[j]} !== 3'b101)
                begin n_bad++; $display("FAIL wplan_done dut%0d: done/early/side %b want 101", j,
                    {obs_done[j], obs_early[j], obs_side_ok[j]}); end
            n_cmp++;
            if (obs_data[j] !== 32'h0)
                begin n_bad++; $display("FAIL wplan_rdata dut%0d: got %h want 0", j, obs_data[j]); end
        end
    endtask

    task automatic test_read_gap();
        logic [31:0] want [2];
        want[0] = 32'h0000CDAB; want[1] = 32'h0000ABCD;
        rxb = '{8'hAB, 8'hCD, 8'h00, 8'h00};
        stall = '{0, 2, 0, 0};
        do_txn(1'b0, 2'd1, $urandom);
        #1;
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({obs_acc[j], obs_done[j], obs_early[j], obs_side_ok[j]} !== 4'b1101)
                begin n_bad++; $display("FAIL rgap_timing dut%0d: acc/done/early/side %b want 1101",
                    j, {obs_acc[j], obs_done[j], obs_early[j], obs_side_ok[j]}); end
            n_cmp++;
            if (obs_data[j] !== want[j])
                begin n_bad++; $display("FAIL rgap_rdata dut%0d: got %h want %h", j, obs_data[j],
                    want[j]); end
            n_cmp++;
            if ({rxr[j], bsy[j]} !== 2'b00)
                begin n_bad++; $display("FAIL rgap_after dut%0d: rx_ready/busy %b want 00", j,
                    {rxr[j], bsy[j]}); end
            n_cmp++;
            if (rdata[j] !== want[j])
                begin n_bad++; $display("FAIL rgap_hold dut%0d: got %h want %h", j, rdata[j],
                    want[j]); end
        end
    endtask

    task automatic test_write_stall();
        logic [31:0] d;
        d = $urandom;
        stall = '{3, 0, 0, 0};
        do_txn(1'b1, 2'd0, d);
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({obs_stall_ok[j], obs_side_ok[j], obs_early[j], obs_done[j]} !== 4'b1101)
                begin n_bad++; $display("FAIL wstall_flags dut%0d: stable/side/early/done %b want 1101",
                    j, {obs_stall_ok[j], obs_side_ok[j], obs_early[j], obs_done[j]}); end
            n_cmp++;
            if (obs_tx[j][0] !== d[7:0])
                begin n_bad++; $display("FAIL wstall_byte dut%0d: got %h want %h", j, obs_tx[j][0],
                    d[7:0]); end
        end
    endtask

    task automatic test_no_queue();
        logic [7:0] b;
        b = 8'($urandom);
        req_order = 1'b1; req_write = 1'b1; req_size = 2'd1; req_data = $urandom;
        tx_ready = 1'b1; rx_valid = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (acc[j] !== 1'b1)
                begin n_bad++; $display("FAIL noq_first dut%0d: got %b want 1", j, acc[j]); end
        end
        tick();
        req_write = 1'b0; req_size = 2'd0;
        for (int c = 1; c <= 3; c++) begin
            #1;
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if ({acc[j], done[j]} !== {1'b0, c == 3})
                    begin n_bad++; $display("FAIL noq_cycle%0d dut%0d: acc/done %b want %b", c, j,
                        {acc[j], done[j]}, {1'b0, c == 3}); end
            end
            tick();
        end
        #1;
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (acc[j] !== 1'b1)
                begin n_bad++; $display("FAIL noq_second dut%0d: got %b want 1", j, acc[j]); end
        end
        tick();
        req_order = 1'b0; tx_ready = 1'b0; rx_valid = 1'b1; rx_data = b;
        tick();
        rx_valid = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({done[j], rdata[j]} !== {1'b1, 24'h0, b})
                begin n_bad++; $display("FAIL noq_read dut%0d: done %b data %h want 1 %h", j,
                    done[j], rdata[j], {24'h0, b}); end
        end
        tick();
    endtask

    task automatic test_reset_mid_rx();
        logic [7:0] nb;
        nb = 8'($urandom);
        req_order = 1'b1; req_write = 1'b0; req_size = 2'd3; rx_valid = 1'b0;
        tick();
        req_order = 1'b0; rx_valid = 1'b1;
        rx_data = 8'($urandom) | 8'h01; tick();
        rx_data = 8'($urandom) | 8'h01; tick();
        rstn = 1'b1; tick();
        rstn = 1'b0;
        #1;
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({acc[j], done[j], txv[j], rxr[j], bsy[j], rdata[j], txd[j]} !== 45'h0)
                begin n_bad++; $display("FAIL rstmid_outs dut%0d: flags %b data %h txd %h want 0",
                    j, {acc[j], done[j], txv[j], rxr[j], bsy[j]}, rdata[j], txd[j]); end
        end
        tick();
        rxb = '{nb, 8'h00, 8'h00, 8'h00};
        stall = '{0, 0, 0, 0};
        do_txn(1'b0, 2'd0, $urandom);
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if ({obs_done[j], obs_data[j]} !== {1'b1, 24'h0, nb})
                begin n_bad++; $display("FAIL rstmid_read dut%0d: done %b data %h want 1 %h", j,
                    obs_done[j], obs_data[j], {24'h0, nb}); end
        end
    endtask

    task automatic test_endian_read();
        logic [31:0] want [2];
        want[0] = 32'h00000201; want[1] = 32'h00000102;
        rxb = '{8'h01, 8'h02, 8'h00, 8'h00};
        stall = '{0, 0, 0, 0};
        do_txn(1'b0, 2'd1, $urandom);
        for (int j = 0; j < 2; j++) begin
            n_cmp++;
            if (obs_data[j] !== want[j])
                begin n_bad++; $display("FAIL endian_read dut%0d: got %h want %h", j, obs_data[j],
                    want[j]); end
        end
    endtask

    // Consecutive random transactions: each starts in the first cycle acceptance is legal.
    task automatic test_random_back_to_back();
        for (int t = 0; t < 40; t++) begin
            logic        wr;
            logic [1:0]  sz;
            logic [31:0] d;
            int          n;
            wr = 1'($urandom); sz = 2'($urandom); d = $urandom; n = int'(sz) + 1;
            for (int k = 0; k < 4; k++) begin
                stall[k] = int'($urandom_range(0, 2));
                rxb[k] = 8'($urandom);
            end
            do_txn(wr, sz, d);
            for (int j = 0; j < 2; j++) begin
                n_cmp++;
                if ({obs_acc[j], obs_done[j], obs_early[j], obs_side_ok[j], obs_stall_ok[j]}
                    !== 5'b11011)
                    begin n_bad++; $display("FAIL rand%0d_flags dut%0d: %b want 11011", t, j,
                        {obs_acc[j], obs_done[j], obs_early[j], obs_side_ok[j],
                         obs_stall_ok[j]}); end
                n_cmp++;
                if (obs_data[j] !== (wr ? 32'h0 : exp_rd(j, n)))
                    begin n_bad++; $display("FAIL rand%0d_rdata dut%0d: got %h want %h", t, j,
                        obs_data[j], wr ? 32'h0 : exp_rd(j, n)); end
                if (wr) begin
                    for (int k = 0; k < n; k++) begin
                        n_cmp++;
                        if (obs_tx[j][k] !== exp_tx(j, d, n, k))
                            begin n_bad++; $display("FAIL rand%0d_byte%0d dut%0d: got %h want %h",
                                t, k, j, obs_tx[j][k], exp_tx(j, d, n, k)); end
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_plan();
        test_read_gap();
        test_write_stall();
        test_no_queue();
        test_reset_mid_rx();
        test_endian_read();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_io_server.md
# uart_io_server

UART-side responder for the I/O request channel issued by the execution stage. It accepts one read or write request at a time, of 1–4 bytes, and serialises write data onto the UART transmitter byte stream. For reads it assembles bytes from the UART receiver stream. When the transfer finishes it returns a one-cycle done pulse with the result word. The block sits between the core's packed to-UART/from-UART buses and the byte-level UART TX/RX units.

## Interface
Parameters:
- `LITTLE_ENDIAN`, default 1. 1: byte 0 is bits [7:0], sent and received first. 0: byte 0 is the most significant byte of the transfer.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rstn`  in  1  synchronous reset, asserted high
- `req_order`  in  1  request present this cycle
- `req_size`  in  2  byte count minus one (0→1 byte … 3→4 bytes)
- `req_data`  in  32  write data
- `req_write`  in  1  1 = write to TX, 0 = read from RX
- `resp_accepted`  out  1  request taken this cycle
- `resp_done`  out  1  one-cycle completion pulse
- `resp_data`  out  32  read result, valid while `resp_done` is high
- `tx_data`  out  8  byte to transmitter
- `tx_valid`  out  1  `tx_data` valid
- `tx_ready`  in  1  transmitter takes byte when `tx_valid & tx_ready`
- `rx_data`  in  8  byte from receiver
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  byte consumed when `rx_valid & rx_ready`
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, TX, RX, DONE.
- **IDLE**
  - `resp_accepted = req_order`, combinational, same cycle.
  - On `req_order`, latch `req_size`, `req_data` and `req_write`, and clear the byte counter.
  - Next state is TX if `req_write`, else RX.
- **TX**
  - `tx_valid = 1`; `tx_data` = latched byte indexed by the counter, ordered per `LITTLE_ENDIAN`.
  - On each handshake the counter increments.
  - On the handshake where counter == size, go to DONE.
  - `tx_data` must stay stable while `tx_valid & ~tx_ready`.
- **RX**
  - `rx_ready = 1`.
  - On each handshake the byte is stored into its lane of the result register and the counter increments.
  - Unfilled upper lanes read zero. With `LITTLE_ENDIAN=0`, the result is right-aligned: the first byte is most significant within the `size+1` bytes.
  - Last handshake → DONE.
- **DONE**
  - `resp_done = 1` for exactly one cycle.
  - `resp_data` = assembled word for reads, 32'b0 for writes.
  - Next state is IDLE.
- `resp_accepted` is 0 in every state except IDLE, so requests are never queued. The requester must keep `req_order` asserted until it sees acceptance.
- `rx_valid` outside RX is ignored and the byte is not consumed (`rx_ready = 0`).
- `resp_data` holds its last value outside DONE.
- Reset in any state:
  - state → IDLE; counter, latches and result register → 0.
  - A partially transmitted word is abandoned. `tx_valid` drops in the next cycle even if the byte was not taken.
- Reset values: `resp_accepted` 0 (no order), `resp_done` 0, `resp_data` 0, `tx_valid` 0, `tx_data` 0, `rx_ready` 0, `busy` 0.

## Timing
- Accept in cycle 0. First TX/RX byte is offered in cycle 1.
- With `tx_ready`/`rx_valid` always high: n bytes occupy cycles 1..n, `resp_done` in cycle n+1, next acceptance possible in cycle n+2.
- Each stall cycle (`tx_ready=0` or `rx_valid=0`) adds exactly one cycle.
- No combinational path from `tx_ready`/`rx_valid` to `resp_done`.
- `resp_accepted` depends combinationally on `req_order` only, gated by the registered state.

## Structure
- Shared package `uart_io_pkg` holds:
  - the state enum (IDLE/TX/RX/DONE);
  - `LEN_UART_SIZE = 2`;
  - a `size_to_last_idx` function;
  - pack/unpack of the to-UART request and from-UART response bundles, so the core side and this block agree on field order.
- One sub-module: `io_byte_lane`, a 2-bit counter plus byte-lane mux/demux with endian select. The FSM lives in the top module.

## Test plan
- Write, size 3, data 32'h11223344, LE, `tx_ready` high → accepted in cycle 0; bytes 44,33,22,11 in cycles 1–4; `resp_done` in cycle 5 with `resp_data` 0.
- Read, size 1, RX bytes AB then CD with 2 idle cycles between → `resp_data` 32'h0000CDAB; `resp_done` in cycle 5; `rx_ready` low after.
- Write, size 0, `tx_ready` low for 3 cycles → `tx_data` stable and `tx_valid` held; done 1 cycle after the handshake.
- Second `req_order` during TX → `resp_accepted` 0 until the cycle after DONE; then accepted.
- Reset asserted mid-RX after 2 of 4 bytes → all outputs 0 next cycle, `busy` 0. A subsequent 1-byte read returns only the new byte.
- `LITTLE_ENDIAN=0`, write size 3, data 32'h11223344 → bytes 11,22,33,44; read of bytes 01,02 with size 1 → 32'h00000102.
